// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache refilled from byte-wide program memory.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_fetch #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_BITS  = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rom_ce_i,
    input  logic [31:0]          rom_addr_i,
    output logic [31:0]          rom_data_o,
    output logic                 rom_valid_o,
    input  logic                 flush_i,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic                 mem_rd_o,
    input  logic [7:0]           mem_data_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    // state | meaning
    // IDLE  | lookup; a miss latches the line address and starts a refill
    // FETCH | issue byte reads 0..3, capturing the previous byte each cycle
    // DRAIN | capture byte 3 and write the line unless a flush intervened
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   miss_addr_q, miss_addr_d;
    logic [23:0]            buf_q, buf_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_BITS-1:0]    tag_q [LINES];
    logic [31:0]            data_q [LINES];

    logic [INDEX_BITS-1:0]  idx, fill_idx;
    logic [TAG_BITS-1:0]    tag;
    logic                   hit, fill_we;
    logic                   unused_addr_bits;

    assign idx      = rom_addr_i[INDEX_BITS+1:2];
    assign tag      = rom_addr_i[ADDR_BITS-1:INDEX_BITS+2];
    assign fill_idx = miss_addr_q[INDEX_BITS+1:2];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign unused_addr_bits = ^{rom_addr_i[31:ADDR_BITS], rom_addr_i[1:0]};

    assign rom_valid_o = rom_ce_i && (state_q == IDLE) && hit;
    assign rom_data_o  = rom_valid_o ? data_q[idx] : 32'h0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        miss_addr_d  = miss_addr_q;
        buf_d        = buf_q;
        flush_pend_d = flush_pend_q;
        mem_rd_o     = 1'b0;
        mem_addr_o   = '0;
        fill_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rom_ce_i && !hit && !flush_i) begin
                    miss_addr_d  = {rom_addr_i[ADDR_BITS-1:2], 2'b00};
                    cnt_d        = 2'd0;
                    flush_pend_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = miss_addr_q | {{(ADDR_BITS-2){1'b0}}, cnt_q};
                // Data returned this cycle belongs to the read issued last cycle.
                case (cnt_q)
                    2'd1:    buf_d[7:0]   = mem_data_i;
                    2'd2:    buf_d[15:8]  = mem_data_i;
                    2'd3:    buf_d[23:16] = mem_data_i;
                    default: ;
                endcase
                cnt_d = cnt_q + 2'd1;
                if (flush_i)
                    flush_pend_d = 1'b1;
                if (cnt_q == 2'd3)
                    state_d = DRAIN;
            end
            DRAIN: begin
                fill_we = !flush_pend_q && !flush_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (flush_i)
            valid_d = '0;
        else if (fill_we)
            valid_d[fill_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            miss_addr_q  <= '0;
            buf_q        <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_addr_q  <= miss_addr_d;
            buf_q        <= buf_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
        end
    end

    // Payload arrays need no reset; valid_q gates every read.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_idx] <= {mem_data_i, buf_q};
            tag_q[fill_idx]  <= miss_addr_q[ADDR_BITS-1:INDEX_BITS+2];
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_o  <= 32'h0;
            miss_cnt_o <= 32'h0;
        end else begin
            if (rom_valid_o)
                hit_cnt_o <= hit_cnt_o + 32'h1;
            if (state_q == IDLE && state_d == FETCH)
                miss_cnt_o <= miss_cnt_o + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed testbench for icache_fetch: cold miss, hit, conflict, redirect, flush, async reset.
module tb_icache_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        rom_valid_o;
    logic        flush_i;
    logic [16:0] mem_addr_o;
    logic        mem_rd_o;
    logic [7:0]  mem_data_i;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [0:1023];

    icache_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .rom_valid_o(rom_valid_o),
        .flush_i    (flush_i),
        .mem_addr_o (mem_addr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_data_i (mem_data_i)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Program memory: read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_o)
            mem_data_i <= mem[mem_addr_o[9:0]];
        else
            mem_data_i <= 8'h00;
    end

    task automatic put_word(input int addr, input logic [31:0] w);
        mem[addr]   = w[7:0];
        mem[addr+1] = w[15:8];
        mem[addr+2] = w[23:16];
        mem[addr+3] = w[31:24];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From IDLE with the miss address already applied (cycle 0): check the
    // four issues, the silent drain cycle, and the hit in cycle 6.
    task automatic refill(input string tag, input logic [31:0] addr, input logic [31:0] w);
        chk({tag, "_c0_valid"}, {31'd0, rom_valid_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk({tag, "_rd"}, {31'd0, mem_rd_o}, 32'd1);
            chk({tag, "_addr"}, {15'd0, mem_addr_o}, addr + k);
            chk({tag, "_stall"}, {31'd0, rom_valid_o}, 32'd0);
        end
        tick();
        chk({tag, "_c5_rd"}, {31'd0, mem_rd_o}, 32'd0);
        chk({tag, "_c5_valid"}, {31'd0, rom_valid_o}, 32'd0);
        tick();
        chk({tag, "_c6_valid"}, {31'd0, rom_valid_o}, 32'd1);
        chk({tag, "_c6_data"}, rom_data_o, w);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        put_word(32'h010, 32'h12345678);
        put_word(32'h014, 32'hAABBCCDD);
        put_word(32'h110, 32'h11223344);
        put_word(32'h020, 32'hCAFEF00D);
        put_word(32'h040, 32'h0BADBEEF);
        put_word(32'h030, 32'h5EED1234);

        rst = 1'b0; rom_ce_i = 1'b0; rom_addr_i = 32'h0; flush_i = 1'b0;
        #12;
        chk("rst_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("rst_addr", {15'd0, mem_addr_o}, 32'd0);
        chk("rst_valid", {31'd0, rom_valid_o}, 32'd0);
        chk("rst_data", rom_data_o, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // T1 cold miss
        rom_ce_i = 1'b1; rom_addr_i = 32'h10; #1;
        refill("t1", 32'h10, 32'h12345678);

        // T2 second line, then hit on the first with no memory traffic
        rom_addr_i = 32'h14; #1;
        refill("t2", 32'h14, 32'hAABBCCDD);
        rom_addr_i = 32'h10; #1;
        chk("t2_hit_valid", {31'd0, rom_valid_o}, 32'd1);
        chk("t2_hit_data", rom_data_o, 32'h12345678);
        tick();
        chk("t2_hit_nord", {31'd0, mem_rd_o}, 32'd0);
        rom_ce_i = 1'b0; #1;
        chk("t2_ce0_valid", {31'd0, rom_valid_o}, 32'd0);
        chk("t2_ce0_data", rom_data_o, 32'd0);

        // T3 conflict on index 4
        rom_ce_i = 1'b1; rom_addr_i = 32'h110; #1;
        refill("t3", 32'h110, 32'h11223344);
        rom_addr_i = 32'h10; #1;
        refill("t3_back", 32'h10, 32'h12345678);

        // T4 redirect in cycle 2
        rom_addr_i = 32'h20; #1;
        chk("t4_c0_valid", {31'd0, rom_valid_o}, 32'd0);
        tick();
        chk("t4_c1_addr", {15'd0, mem_addr_o}, 32'h20);
        tick();
        rom_addr_i = 32'h40; #1;
        chk("t4_c2_addr", {15'd0, mem_addr_o}, 32'h21);
        tick();
        chk("t4_c3_addr", {15'd0, mem_addr_o}, 32'h22);
        tick();
        chk("t4_c4_addr", {15'd0, mem_addr_o}, 32'h23);
        tick();
        chk("t4_c5_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("t4_c5_valid", {31'd0, rom_valid_o}, 32'd0);
        tick();
        refill("t4_new", 32'h40, 32'h0BADBEEF);
        rom_addr_i = 32'h20; #1;
        chk("t4_old_valid", {31'd0, rom_valid_o}, 32'd1);
        chk("t4_old_data", rom_data_o, 32'hCAFEF00D);

        // T5 flush in cycle 3 of a refill
        rom_addr_i = 32'h30; #1;
        tick(); tick(); tick();
        flush_i = 1'b1;
        chk("t5_c3_rd", {31'd0, mem_rd_o}, 32'd1);
        tick();
        flush_i = 1'b0;
        chk("t5_c4_addr", {15'd0, mem_addr_o}, 32'h33);
        tick();
        chk("t5_c5_rd", {31'd0, mem_rd_o}, 32'd0);
        tick();
        chk("t5_miss30", {31'd0, rom_valid_o}, 32'd0);
        rom_ce_i = 1'b0; rom_addr_i = 32'h10; #1;
        rom_ce_i = 1'b1; #1;
        chk("t5_miss10", {31'd0, rom_valid_o}, 32'd0);
        rom_addr_i = 32'h20; #1;
        chk("t5_miss20", {31'd0, rom_valid_o}, 32'd0);
        rom_addr_i = 32'h10; #1;
        refill("t5_refill", 32'h10, 32'h12345678);

        // T6 async reset mid-FETCH
        rom_addr_i = 32'h20; #1;
        tick(); tick();
        chk("t6_pre_rd", {31'd0, mem_rd_o}, 32'd1);
        #2 rst = 1'b0; #1;
        chk("t6_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("t6_addr", {15'd0, mem_addr_o}, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("t6_hits", hit_cnt_o, 32'd0);
        chk("t6_misses", miss_cnt_o, 32'd0);
`endif
        tick();
        rst = 1'b1;
        rom_addr_i = 32'h10; #1;
        chk("t6_miss10", {31'd0, rom_valid_o}, 32'd0);
        tick();
        chk("t6_refetch", {15'd0, mem_addr_o}, 32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
